// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: start-bit detect, 2-of-3 majority bit sampling,
// optional parity check and stop-bit check, with single-cycle result pulses.
module uart_rx_deserializer #(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [data_width-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CntW = (data_width > 1) ? $clog2(data_width) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q;
  logic [5:0]            edge_cnt_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [data_width-1:0] shift_q;
  logic [5:0]            p_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  s0_q;
  logic                  s1_q;
  logic                  bit_q;
  logic                  par_fail_q;

  logic [5:0] half;
  logic       at_last;
  logic       maj;
  logic       legal_p;

  always_comb begin
    half    = p_q >> 1;
    at_last = (edge_cnt_q == p_q - 6'd1);
    maj     = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    legal_p = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_q        <= 6'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_q      <= 1'b0;
      par_fail_q <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state_q != IDLE) begin
        if (edge_cnt_q == half - 6'd1) s0_q <= RX_IN;
        if (edge_cnt_q == half)        s1_q <= RX_IN;
        if (edge_cnt_q == half + 6'd1) bit_q <= maj;
        edge_cnt_q <= at_last ? 6'd0 : edge_cnt_q + 6'd1;
      end

      unique case (state_q)
        IDLE: begin
          // The detect cycle itself is edge 0 of the start bit.
          if (!RX_IN) begin
            state_q    <= START;
            edge_cnt_q <= 6'd1;
            bit_cnt_q  <= '0;
            par_fail_q <= 1'b0;
            p_q        <= legal_p ? prescale : 6'd8;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
          end
        end
        START: begin
          if (at_last) state_q <= bit_q ? IDLE : DATA;
        end
        DATA: begin
          if (at_last) begin
            shift_q   <= {bit_q, shift_q[data_width-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(data_width - 1)) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_last) begin
            if (bit_q != (^shift_q ^ par_typ_q)) begin
              par_err    <= 1'b1;
              par_fail_q <= 1'b1;
            end
            state_q <= STOP;
          end
        end
        STOP: begin
          if (at_last) begin
            if (!bit_q) begin
              stp_err <= 1'b1;
            end else if (!par_fail_q) begin
              data_valid <= 1'b1;
              P_DATA     <= shift_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven bit by bit and
// output pulses are counted and time-stamped relative to the first low cycle.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_deserializer #(.data_width(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .prescale  (prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dv_n = 0, pe_n = 0, se_n = 0;
  int dv_cyc = 0, dv_prev = 0, pe_cyc = 0, se_cyc = 0;
  always @(negedge clk) begin
    if (data_valid) begin dv_n++; dv_prev = dv_cyc; dv_cyc = cyc; end
    if (par_err) begin pe_n++; pe_cyc = cyc; end
    if (stp_err) begin se_n++; se_cyc = cyc; end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int first_low;
  int dv0, pe0, se0, dv_first;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic snap();
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
  endtask

  // Called at a negedge; the low start bit begins at the next sampling edge.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop);
    prescale  = 6'(p);
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    first_low = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stop, p);
  endtask

  initial begin
    rst = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_pdata", 32'(P_DATA), 32'h0);
    check_eq("reset_pulses", {29'd0, data_valid, par_err, stp_err}, 32'h0);

    // prescale 8, no parity, 0xA5
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("a5_dv_count", 32'(dv_n - dv0), 32'd1);
    check_eq("a5_dv_latency", 32'(dv_cyc - first_low), 32'd80);
    check_eq("a5_pdata", 32'(P_DATA), 32'hA5);
    check_eq("a5_no_err", 32'((pe_n - pe0) + (se_n - se0)), 32'd0);

    // prescale 16, even parity, correct parity bit
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("3c_dv_count", 32'(dv_n - dv0), 32'd1);
    check_eq("3c_dv_latency", 32'(dv_cyc - first_low), 32'd176);
    check_eq("3c_pdata", 32'(P_DATA), 32'h3C);
    check_eq("3c_no_perr", 32'(pe_n - pe0), 32'd0);

    // same frame, wrong parity bit; P_DATA must hold
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("perr_count", 32'(pe_n - pe0), 32'd1);
    check_eq("perr_latency", 32'(pe_cyc - first_low), 32'd160);
    check_eq("perr_no_dv", 32'(dv_n - dv0), 32'd0);
    check_eq("perr_pdata_hold", 32'(P_DATA), 32'h3C);
    check_eq("perr_no_serr", 32'(se_n - se0), 32'd0);

    // prescale 32, low stop bit
    snap();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    RX_IN = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("serr_count", 32'(se_n - se0), 32'd1);
    check_eq("serr_latency", 32'(se_cyc - first_low), 32'd320);
    check_eq("serr_no_dv", 32'(dv_n - dv0), 32'd0);
    check_eq("serr_pdata_hold", 32'(P_DATA), 32'h3C);

    // start glitch, then a good 0x55 frame
    snap();
    prescale = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 12);
    check_eq("glitch_no_pulse", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'd0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("55_dv_count", 32'(dv_n - dv0), 32'd1);
    check_eq("55_pdata", 32'(P_DATA), 32'h55);

    // back-to-back frames
    snap();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    dv_first = first_low;
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("b2b_dv_count", 32'(dv_n - dv0), 32'd2);
    check_eq("b2b_spacing", 32'(dv_cyc - dv_prev), 32'd80);
    check_eq("b2b_first_latency", 32'(dv_prev - dv_first), 32'd80);
    check_eq("b2b_pdata", 32'(P_DATA), 32'h34);

    // reset in the middle of data bit 4 of 0x0F
    snap();
    prescale = 6'd8;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    drive_bit(1'b0, 4);
    rst = 1'b1; RX_IN = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("rst_no_pulse", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'd0);
    check_eq("rst_pdata_zero", 32'(P_DATA), 32'h0);
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("f0_dv_count", 32'(dv_n - dv0), 32'd1);
    check_eq("f0_pdata", 32'(P_DATA), 32'hF0);

    // config changed mid-frame must not affect the frame in flight
    snap();
    prescale  = 6'd8; PAR_EN = 1'b0;
    first_low = cyc;
    drive_bit(1'b0, 8);
    PAR_EN = 1'b1; prescale = 6'd16;
    for (int i = 0; i < 8; i++) drive_bit(i[0], 8);
    drive_bit(1'b1, 8);
    prescale = 6'd8; PAR_EN = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("cfg_hold_dv", 32'(dv_n - dv0), 32'd1);
    check_eq("cfg_hold_latency", 32'(dv_cyc - first_low), 32'd80);
    check_eq("cfg_hold_pdata", 32'(P_DATA), 32'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter: data_width, 8, number of data bits per frame.
REQ-002 SHALL have port: clk  input  1  single clock; RX_IN oversampled at this rate.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: RX_IN  input  1  serial line; idle high; LSB first.
REQ-005 SHALL have port: prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port: PAR_EN  input  1  1 = parity bit present between data and stop.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: P_DATA  output  data_width  last correctly received word.
REQ-009 SHALL have port: data_valid  output  1  one-cycle pulse on a clean frame.
REQ-010 SHALL have port: par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port: stp_err  output  1  one-cycle pulse on a low stop bit.

Function
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL hold each bit for exactly P cycles; edge_cnt runs 0..P-1 (P = prescale); prescale values outside {8,16,32} SHALL be treated as 8.
REQ-014 IDLE: when RX_IN==0 is sampled, that cycle SHALL count as edge_cnt 0 of the start bit, and the next state SHALL be START with edge_cnt=1.
REQ-015 SHALL sample each bit by 2-of-3 majority of RX_IN at edge_cnt P/2-1, P/2 and P/2+1, with the result registered at edge_cnt P/2+1.
REQ-016 START, at edge_cnt P-1: a sampled 0 SHALL go to DATA; a sampled 1 (glitch) SHALL return to IDLE with no output pulse.
REQ-017 DATA: SHALL shift each sampled bit into a data_width shift register LSB first; after bit data_width-1 at edge_cnt P-1, SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-018 PARITY: expected bit SHALL be the XOR of the data bits, XORed with PAR_TYP; on mismatch, SHALL pulse par_err in the cycle after edge_cnt P-1; SHALL always go to STOP.
REQ-019 STOP: SHALL pulse stp_err in the cycle after edge_cnt P-1 if the sampled bit is 0; SHALL return to IDLE in that same cycle.
REQ-020 SHALL pulse data_valid and load P_DATA with the shift register in the cycle after STOP edge_cnt P-1, only if the stop bit is 1 and no parity error occurred in the frame.
REQ-021 On any error, P_DATA SHALL keep its previous value and data_valid SHALL stay 0.
REQ-022 data_valid, par_err and stp_err SHALL each be high for exactly one cycle per event, and SHALL never be high outside the cycles defined above.
REQ-023 Back-to-back frames: after STOP, a start bit beginning in the first IDLE cycle SHALL be detected with no lost cycles.
REQ-024 PAR_EN, PAR_TYP and prescale SHALL be sampled at the start-detect cycle and held for the whole frame; changes mid-frame SHALL have no effect until the next frame.
REQ-025 Frame length SHALL be P*(data_width+2+PAR_EN) cycles, counted from the first low RX_IN cycle through the last stop edge.

Reset
REQ-026 When rst=1 at a clk edge: state SHALL become IDLE; edge_cnt, bit counter and shift register SHALL become 0; P_DATA, data_valid, par_err and stp_err SHALL become 0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no output pulse; the first low RX_IN after rst deasserts SHALL be treated as a new start bit.

Verification
REQ-028 prescale=8, PAR_EN=0, frame 0xA5 (start, data, stop=1) -> data_valid pulses one cycle at cycle 80 after the first low cycle; P_DATA=0xA5; no error pulses.
REQ-029 prescale=16, PAR_EN=1, PAR_TYP=0, frame 0x3C with parity 0 -> data_valid pulses; P_DATA=0x3C. Repeat with parity 1 -> par_err pulses once, no data_valid, P_DATA stays 0x3C.
REQ-030 prescale=32, frame 0x81 with stop bit 0 -> stp_err pulses one cycle at frame end; no data_valid; P_DATA unchanged.
REQ-031 RX_IN low for 2 cycles then high (prescale=8) -> start rejected, FSM back in IDLE, no pulses; a following valid 0x55 frame is received correctly.
REQ-032 Two back-to-back frames 0x12 and 0x34 at prescale=8, PAR_EN=0 -> two data_valid pulses exactly 80 cycles apart.
REQ-033 rst pulsed during DATA bit 4 of a frame -> no pulses; P_DATA=0; the next full frame 0xF0 is received correctly.
